io_port_ctrl: RTL and testbench
===============================

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter DB_COUNT, default 4: number of consecutive cycles a synchronized button must differ from its debounced value before that value toggles (>=2).
REQ-002 Parameter LEDS_ID, default 8'h40: output port address of the LED register.
REQ-003 Parameter SSEG_ID, default 8'h81: output port address of the seven-segment value register.
REQ-004 Parameter SW_ID, default 8'h20: input port address for switches.
REQ-005 Parameter BTN_ID, default 8'h24: input port address for button status.
REQ-006 Parameter INT_ACK_ID, default 8'hF0: output port address for interrupt acknowledge (write-1-to-clear).
REQ-007 Parameter INT_MASK_ID, default 8'hF1: output port address for the interrupt mask.
REQ-008 CLK  in  1  single system clock; all state updates on its rising edge.
REQ-009 RESET_N  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-010 PORT_ID  in  8  I/O address from the MCU.
REQ-011 OUT_PORT  in  8  write data from the MCU.
REQ-012 IO_STRB  in  1  write strobe from the MCU, one cycle per OUT instruction.
REQ-013 SWITCHES  in  8  asynchronous board switches.
REQ-014 BUTTONS  in  4  asynchronous, bouncing board buttons, active-high.
REQ-015 IN_PORT  out  8  read data to the MCU.
REQ-016 LEDS  out  8  LED register.
REQ-017 SSEG_VAL  out  8  seven-segment value register.
REQ-018 INTERRUPT  out  1  level interrupt request to the MCU.

Function
REQ-019 Write decode: at a rising edge with IO_STRB=1, the register whose address equals PORT_ID loads OUT_PORT. Unmatched addresses have no effect. With IO_STRB=0, no register changes.
REQ-020 SWITCHES and BUTTONS each pass through a 2-flop synchronizer before any other use.
REQ-021 Debounce, per button: a counter increments each cycle the synchronized bit differs from the debounced bit. On any cycle they match, the counter returns to 0. When the counter equals DB_COUNT-1 and the bits still differ, the debounced bit toggles and the counter returns to 0.
REQ-022 Latency: when a button input goes and stays high, its debounced bit rises on rising edge DB_COUNT+2, counting the first edge that samples the input as edge 1. Shorter pulses produce no change.
REQ-023 Pending[i] sets on the same edge debounced[i] goes 0->1. A falling debounced edge does not set pending.
REQ-024 An INT_ACK_ID write clears pending[i] where OUT_PORT[i]=1. OUT_PORT[7:4] is ignored.
REQ-025 If a set and an acknowledge of the same pending bit occur on the same edge, the set wins.
REQ-026 An INT_MASK_ID write loads mask[3:0] from OUT_PORT[3:0].
REQ-027 INTERRUPT = OR of (pending & mask), combinational from registers. It stays high until acknowledged or masked.
REQ-028 Read mux, combinational, by PORT_ID:
- SW_ID: synchronized switches.
- BTN_ID: {pending[3:0], debounced[3:0]}.
- INT_MASK_ID: {4'h0, mask}.
- any other address: 8'h00.
REQ-029 Reads have no side effects. Pending is never cleared by a read.
REQ-030 Simultaneous rising debounced edges on several buttons set all corresponding pending bits on the same edge.

Reset
REQ-031 RESET_N low asynchronously forces the following, independent of CLK:
- LEDS=8'h00, SSEG_VAL=8'h00
- mask=4'hF, pending=4'h0, debounced=4'h0
- all counters and synchronizer flops to 0
- INTERRUPT=0
REQ-032 Reset asserted mid-debounce discards the partial count. After RESET_N rises, a held button requires the full REQ-022 latency again.
REQ-033 The first rising edge after RESET_N deasserts performs normal operation.

Verification
REQ-034 PORT_ID=8'h40, OUT_PORT=8'hA5, IO_STRB=1 for one cycle -> LEDS=8'hA5 next edge, SSEG_VAL unchanged. The same write with IO_STRB=0 -> LEDS unchanged.
REQ-035 BUTTONS[0] held high, DB_COUNT=4 -> debounced[0] and INTERRUPT rise at edge 6. A read at BTN_ID returns 8'h11.
REQ-036 BUTTONS[2] toggled 1/0 every 2 cycles for 40 cycles -> debounced[2] stays 0 and INTERRUPT stays 0.
REQ-037 Pending=4'h1, then write 8'h01 to 8'hF0 on the same edge button 0 re-rises -> pending[0] stays 1. The same write on a quiet cycle -> INTERRUPT=0 next edge.
REQ-038 Mask write 8'h00, then a button 1 press -> pending[1]=1, INTERRUPT=0. Mask write 8'h02 -> INTERRUPT=1 next edge.
REQ-039 RESET_N pulsed low asynchronously with button held and count at 2 -> all outputs zero immediately. After release, debounced rises only at edge 6 again.

Source files
------------

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: MCU I/O port block with write-decoded output registers,
// synchronized switch/button inputs, per-button debounce, and a masked
// rising-edge button interrupt with write-1-to-clear acknowledge.
module io_port_ctrl #(
  parameter int unsigned DB_COUNT    = 4,
  parameter logic [7:0]  LEDS_ID     = 8'h40,
  parameter logic [7:0]  SSEG_ID     = 8'h81,
  parameter logic [7:0]  SW_ID       = 8'h20,
  parameter logic [7:0]  BTN_ID      = 8'h24,
  parameter logic [7:0]  INT_ACK_ID  = 8'hF0,
  parameter logic [7:0]  INT_MASK_ID = 8'hF1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] IN_PORT,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL,
  output logic       INTERRUPT
);

  localparam int unsigned   CW      = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic [7:0]    sw_s1_q, sw_s2_q;
  logic [3:0]    btn_s1_q, btn_s2_q;

  logic [7:0]    leds_q, leds_d;
  logic [7:0]    sseg_q, sseg_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    db_q, db_d;
  logic [3:0]    db_rise;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic          wr_leds, wr_sseg, wr_ack, wr_mask;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= SWITCHES;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= BUTTONS;
      btn_s2_q <= btn_s1_q;
    end
  end

  // Write-strobe address decode.
  always_comb begin
    wr_leds = IO_STRB && (PORT_ID == LEDS_ID);
    wr_sseg = IO_STRB && (PORT_ID == SSEG_ID);
    wr_ack  = IO_STRB && (PORT_ID == INT_ACK_ID);
    wr_mask = IO_STRB && (PORT_ID == INT_MASK_ID);
  end

  // Per-button debounce: count consecutive disagreeing cycles, toggle on the
  // DB_COUNT-th one; the toggle is taken when the count already sits at
  // DB_COUNT-1 so that edge itself is the last disagreeing sample.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    db_rise = db_d & ~db_q;
  end

  // Next state of the MCU-visible registers; a new rising edge overrides a
  // same-cycle acknowledge of that bit.
  always_comb begin
    leds_d = leds_q;
    sseg_d = sseg_q;
    mask_d = mask_q;
    pend_d = pend_q;
    if (wr_leds) leds_d = OUT_PORT;
    if (wr_sseg) sseg_d = OUT_PORT;
    if (wr_mask) mask_d = OUT_PORT[3:0];
    if (wr_ack)  pend_d = pend_q & ~OUT_PORT[3:0];
    pend_d = pend_d | db_rise;
  end

  // Register state: debounce counters, debounced bits, and port registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q <= '0;
      sseg_q <= '0;
      mask_q <= '1;
      pend_q <= '0;
      db_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      leds_q <= leds_d;
      sseg_q <= sseg_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      db_q   <= db_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    IN_PORT = '0;
    if (PORT_ID == SW_ID) begin
      IN_PORT = sw_s2_q;
    end else if (PORT_ID == BTN_ID) begin
      IN_PORT = {pend_q, db_q};
    end else if (PORT_ID == INT_MASK_ID) begin
      IN_PORT = {4'h0, mask_q};
    end
  end

  assign LEDS      = leds_q;
  assign SSEG_VAL  = sseg_q;
  assign INTERRUPT = |(pend_q & mask_q);

endmodule

// File: tb/tb_io_port_ctrl.sv
// Testbench for io_port_ctrl: directed scenarios plus randomized traffic
// checked against a history-window behavioural model.
module tb_io_port_ctrl;

  localparam int unsigned DB      = 4;
  localparam logic [7:0]  LEDS_ID = 8'h40;
  localparam logic [7:0]  SSEG_ID = 8'h81;
  localparam logic [7:0]  SW_ID   = 8'h20;
  localparam logic [7:0]  BTN_ID  = 8'h24;
  localparam logic [7:0]  ACK_ID  = 8'hF0;
  localparam logic [7:0]  MASK_ID = 8'hF1;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] SWITCHES = 8'h00;
  logic [3:0] BUTTONS = 4'h0;
  logic [7:0] IN_PORT, LEDS, SSEG_VAL;
  logic       INTERRUPT;

  int checks = 0;
  int failures = 0;

  io_port_ctrl #(
    .DB_COUNT(DB), .LEDS_ID(LEDS_ID), .SSEG_ID(SSEG_ID), .SW_ID(SW_ID),
    .BTN_ID(BTN_ID), .INT_ACK_ID(ACK_ID), .INT_MASK_ID(MASK_ID)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .SWITCHES(SWITCHES), .BUTTONS(BUTTONS),
    .IN_PORT(IN_PORT), .LEDS(LEDS), .SSEG_VAL(SSEG_VAL), .INTERRUPT(INTERRUPT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: inputs seen two edges late; a button toggles once the
  // last DB synchronized samples all disagree with its debounced value.
  logic [7:0] m_leds, m_sseg;
  logic [3:0] m_mask, m_pend, m_db;
  logic [7:0] sw_hist[$];
  logic [3:0] btn_hist[$];
  logic [3:0] ev_hist[$];

  task automatic model_reset();
    m_leds = 8'h00; m_sseg = 8'h00; m_mask = 4'hF; m_pend = 4'h0; m_db = 4'h0;
    sw_hist = '{8'h00, 8'h00};
    btn_hist = '{4'h0, 4'h0};
    ev_hist.delete();
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] pid);
    if (pid == SW_ID) return sw_hist[0];
    if (pid == BTN_ID) return {m_pend, m_db};
    if (pid == MASK_ID) return {4'h0, m_mask};
    return 8'h00;
  endfunction

  function automatic logic m_int();
    return |(m_pend & m_mask);
  endfunction

  function automatic logic [7:0] pick_pid();
    case ($urandom_range(0, 6))
      0: return LEDS_ID;
      1: return SSEG_ID;
      2: return SW_ID;
      3: return BTN_ID;
      4: return ACK_ID;
      5: return MASK_ID;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [7:0] pid, input logic [7:0] dat, input logic st);
    PORT_ID = pid; OUT_PORT = dat; IO_STRB = st;
  endtask

  // One clock edge: capture what the DUT samples, advance the model, settle.
  task automatic tick();
    logic [7:0] pid, dat, sw;
    logic       st;
    logic [3:0] b, ev, nd, rise;
    bit         all_diff;
    pid = PORT_ID; dat = OUT_PORT; st = IO_STRB; sw = SWITCHES; b = BUTTONS;
    @(posedge CLK);
    ev = btn_hist[0];
    btn_hist.push_back(b);
    void'(btn_hist.pop_front());
    sw_hist.push_back(sw);
    void'(sw_hist.pop_front());
    ev_hist.push_back(ev);
    if (ev_hist.size() > DB) void'(ev_hist.pop_front());
    nd = m_db;
    if (ev_hist.size() == DB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        foreach (ev_hist[k]) if (ev_hist[k][i] == m_db[i]) all_diff = 1'b0;
        if (all_diff) nd[i] = ~m_db[i];
      end
    end
    rise = nd & ~m_db;
    if (st && pid == ACK_ID) m_pend = m_pend & ~dat[3:0];
    m_pend = m_pend | rise;
    m_db = nd;
    if (st && pid == LEDS_ID) m_leds = dat;
    if (st && pid == SSEG_ID) m_sseg = dat;
    if (st && pid == MASK_ID) m_mask = dat[3:0];
    #1;
  endtask

  task automatic quiesce();
    BUTTONS = 4'h0;
    drive(BTN_ID, 8'h00, 1'b0);
    repeat (DB + 4) tick();
    drive(ACK_ID, 8'h0F, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    SWITCHES = 8'h5C;
    #2 RESET_N = 1'b0;
    model_reset();
    drive(MASK_ID, 8'h00, 1'b0);
    #1;
    checks++; if (LEDS !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", LEDS); end
    checks++; if (SSEG_VAL !== 8'h00) begin failures++; $display("FAIL reset_sseg got=%h exp=00", SSEG_VAL); end
    checks++; if (INTERRUPT !== 1'b0) begin failures++; $display("FAIL reset_int got=%b exp=0", INTERRUPT); end
    checks++; if (IN_PORT !== 8'h0F) begin failures++; $display("FAIL reset_mask got=%h exp=0f", IN_PORT); end
    drive(BTN_ID, 8'h00, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (IN_PORT !== 8'h00) begin failures++; $display("FAIL reset_btn got=%h exp=00", IN_PORT); end
    PORT_ID = SW_ID;
    #1;
    checks++; if (IN_PORT !== 8'h00) begin failures++; $display("FAIL reset_sw got=%h exp=00", IN_PORT); end
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    drive(LEDS_ID, 8'h3C, 1'b1);
    tick();
    checks++; if (LEDS !== 8'h3C || LEDS !== m_leds) begin failures++; $display("FAIL first_edge_write got=%h exp=3c", LEDS); end
    drive(SW_ID, 8'h00, 1'b0);
    tick();
    checks++; if (IN_PORT !== m_read(SW_ID)) begin failures++; $display("FAIL sw_sync got=%h exp=%h", IN_PORT, m_read(SW_ID)); end
    tick();
    checks++; if (IN_PORT !== 8'h5C) begin failures++; $display("FAIL sw_sync2 got=%h exp=5c", IN_PORT); end
  endtask

  task automatic test_write_decode();
    logic [7:0] sseg_before;
    sseg_before = m_sseg;
    drive(LEDS_ID, 8'hA5, 1'b1);
    tick();
    checks++; if (LEDS !== 8'hA5) begin failures++; $display("FAIL wr_leds got=%h exp=a5", LEDS); end
    checks++; if (SSEG_VAL !== sseg_before) begin failures++; $display("FAIL wr_sseg_untouched got=%h exp=%h", SSEG_VAL, sseg_before); end
    drive(LEDS_ID, 8'h5A, 1'b0);
    tick();
    checks++; if (LEDS !== 8'hA5) begin failures++; $display("FAIL wr_nostrb got=%h exp=a5", LEDS); end
    for (int n = 0; n < 40; n++) begin
      drive(pick_pid(), 8'($urandom), 1'($urandom_range(0, 1)));
      SWITCHES = 8'($urandom);
      tick();
      checks++; if (LEDS !== m_leds) begin failures++; $display("FAIL rnd_leds got=%h exp=%h", LEDS, m_leds); end
      checks++; if (SSEG_VAL !== m_sseg) begin failures++; $display("FAIL rnd_sseg got=%h exp=%h", SSEG_VAL, m_sseg); end
      checks++; if (IN_PORT !== m_read(PORT_ID)) begin failures++; $display("FAIL rnd_read pid=%h got=%h exp=%h", PORT_ID, IN_PORT, m_read(PORT_ID)); end
    end
    drive(MASK_ID, 8'h0F, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
  endtask

  task automatic test_debounce_latency();
    logic exp;
    quiesce();
    BUTTONS = 4'b0001;
    for (int k = 1; k <= int'(DB) + 3; k++) begin
      tick();
      exp = (k >= int'(DB) + 2);
      checks++; if (IN_PORT[0] !== exp || IN_PORT[0] !== m_db[0]) begin failures++; $display("FAIL db_latency edge=%0d got=%b exp=%b", k, IN_PORT[0], exp); end
      checks++; if (INTERRUPT !== exp) begin failures++; $display("FAIL db_int edge=%0d got=%b exp=%b", k, INTERRUPT, exp); end
    end
    checks++; if (IN_PORT !== 8'h11 || IN_PORT !== m_read(BTN_ID)) begin failures++; $display("FAIL btn_read got=%h exp=11", IN_PORT); end
  endtask

  task automatic test_bounce();
    drive(ACK_ID, 8'h0F, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
    for (int c = 0; c < 40; c++) begin
      BUTTONS[2] = ((c / 2) % 2) == 0;
      tick();
      checks++; if (IN_PORT[2] !== 1'b0 || IN_PORT !== m_read(BTN_ID)) begin failures++; $display("FAIL bounce_db c=%0d got=%h exp=%h", c, IN_PORT, m_read(BTN_ID)); end
      checks++; if (INTERRUPT !== 1'b0) begin failures++; $display("FAIL bounce_int c=%0d got=%b exp=0", c, INTERRUPT); end
    end
    BUTTONS[2] = 1'b0;
  endtask

  task automatic test_ack_collision();
    BUTTONS[0] = 1'b0;
    repeat (DB + 4) tick();
    BUTTONS[0] = 1'b1;
    repeat (DB + 2) tick();
    BUTTONS[0] = 1'b0;
    repeat (DB + 4) tick();
    checks++; if (IN_PORT !== 8'h10) begin failures++; $display("FAIL pend_held got=%h exp=10", IN_PORT); end
    BUTTONS[0] = 1'b1;
    repeat (DB + 1) tick();
    drive(ACK_ID, 8'h01, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
    #1;
    checks++; if (IN_PORT !== 8'h11 || IN_PORT !== m_read(BTN_ID)) begin failures++; $display("FAIL set_wins got=%h exp=11", IN_PORT); end
    checks++; if (INTERRUPT !== 1'b1) begin failures++; $display("FAIL set_wins_int got=%b exp=1", INTERRUPT); end
    drive(ACK_ID, 8'hF1, 1'b1);
    tick();
    checks++; if (INTERRUPT !== 1'b0 || INTERRUPT !== m_int()) begin failures++; $display("FAIL quiet_ack_int got=%b exp=0", INTERRUPT); end
    drive(BTN_ID, 8'h00, 1'b0);
  endtask

  task automatic test_mask();
    drive(MASK_ID, 8'h00, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
    BUTTONS[1] = 1'b1;
    repeat (DB + 2) tick();
    checks++; if (IN_PORT[5] !== 1'b1 || IN_PORT !== m_read(BTN_ID)) begin failures++; $display("FAIL masked_pend got=%h exp=%h", IN_PORT, m_read(BTN_ID)); end
    checks++; if (INTERRUPT !== 1'b0) begin failures++; $display("FAIL masked_int got=%b exp=0", INTERRUPT); end
    drive(MASK_ID, 8'h02, 1'b1);
    tick();
    checks++; if (INTERRUPT !== 1'b1) begin failures++; $display("FAIL unmask_int got=%b exp=1", INTERRUPT); end
    drive(MASK_ID, 8'h0F, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_debounce();
    logic exp;
    quiesce();
    drive(LEDS_ID, 8'hFF, 1'b1);
    tick();
    drive(SSEG_ID, 8'h77, 1'b1);
    tick();
    drive(BTN_ID, 8'h00, 1'b0);
    BUTTONS[0] = 1'b1;
    repeat (4) tick();
    checks++; if (IN_PORT !== 8'h00) begin failures++; $display("FAIL pre_reset_db got=%h exp=00", IN_PORT); end
    #3 RESET_N = 1'b0;
    model_reset();
    #1;
    checks++; if (LEDS !== 8'h00 || SSEG_VAL !== 8'h00) begin failures++; $display("FAIL async_reset got=%h/%h exp=00/00", LEDS, SSEG_VAL); end
    checks++; if (INTERRUPT !== 1'b0 || IN_PORT !== 8'h00) begin failures++; $display("FAIL async_reset_int got=%b/%h exp=0/00", INTERRUPT, IN_PORT); end
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    for (int k = 1; k <= int'(DB) + 3; k++) begin
      tick();
      exp = (k >= int'(DB) + 2);
      checks++; if (IN_PORT[0] !== exp || IN_PORT !== m_read(BTN_ID)) begin failures++; $display("FAIL post_reset_db edge=%0d got=%h exp=%h", k, IN_PORT, m_read(BTN_ID)); end
      checks++; if (INTERRUPT !== exp) begin failures++; $display("FAIL post_reset_int edge=%0d got=%b exp=%b", k, INTERRUPT, exp); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) BUTTONS[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) SWITCHES = 8'($urandom);
      drive(pick_pid(), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      tick();
      checks++; if (LEDS !== m_leds) begin failures++; $display("FAIL rand_leds n=%0d got=%h exp=%h", n, LEDS, m_leds); end
      checks++; if (SSEG_VAL !== m_sseg) begin failures++; $display("FAIL rand_sseg n=%0d got=%h exp=%h", n, SSEG_VAL, m_sseg); end
      checks++; if (INTERRUPT !== m_int()) begin failures++; $display("FAIL rand_int n=%0d got=%b exp=%b", n, INTERRUPT, m_int()); end
      checks++; if (IN_PORT !== m_read(PORT_ID)) begin failures++; $display("FAIL rand_read n=%0d pid=%h got=%h exp=%h", n, PORT_ID, IN_PORT, m_read(PORT_ID)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_decode();
    test_debounce_latency();
    test_bounce();
    test_ack_collision();
    test_mask();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
